reg_pipe_en_rst: RTL and testbench
==================================

# reg_pipe_en_rst

Parametrised pipeline register chain: WIDTH-bit data passes through DEPTH register stages, each stage with a valid bit. A common enable stalls the whole chain, and a flush input invalidates every stage. It replaces single fixed-width enable/reset registers wherever the datapath needs a multi-cycle, stallable delay with valid tracking. Typical users are retiming stages in front of arithmetic units and alignment of side-band data with pipelined results.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 3, number of register stages (>= 1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset
- CW, $clog2(DEPTH+1), width of count output (derived; do not override)

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  advance enable; 0 = whole chain holds
- flush  input  1  invalidate all stages and the incoming word
- d  input  WIDTH  input data
- d_valid  input  1  d carries a valid word
- q  output  WIDTH  last-stage data
- q_valid  output  1  last-stage valid
- count  output  CW  number of valid stages (only with REG_PIPE_COUNT_EN)

## Operation
- Internal state:
  - stage data s[0..DEPTH-1], WIDTH bits each
  - stage valid v[0..DEPTH-1]
  - count register (when the macro is enabled)
- q = s[DEPTH-1] and q_valid = v[DEPTH-1], driven straight from registers; no combinational path from any input to any output.
- Priority per edge, highest first: rst, flush, en, hold.
- rst=1:
  - every s[i] <= RST_VAL
  - every v[i] <= 0
  - count <= 0
- flush=1 (rst=0):
  - every v[i] <= 0 and count <= 0, regardless of en
  - s[i] hold their values
  - d/d_valid on that edge are discarded
- en=1 (rst=0, flush=0), shift by one stage:
  - v[0] <= d_valid; v[i] <= v[i-1]
  - data is gated by valid: s[0] <= d only if d_valid=1, else s[0] holds
  - s[i] <= s[i-1] only if v[i-1]=1, else s[i] holds
  - invalid bubbles therefore do not toggle data registers
- en=0 (rst=0, flush=0): all s, v and count hold; d/d_valid are ignored.
- Once q_valid goes 0, q keeps the last valid word or RST_VAL.
- Count update (en=1, no flush/rst): count <= count + d_valid - v[DEPTH-1].
  - Computed in CW bits; never exceeds DEPTH and never underflows.
  - Simultaneous entry and exit leave count unchanged.
- DEPTH=1 is legal and behaves as a single enable register with valid.

## Timing
- Latency: a word accepted on edge k (en=1, d_valid=1) appears on q with q_valid=1 after the DEPTH-th en=1 edge counted from k inclusive.
  - With en held high, that is DEPTH cycles.
  - Each en=0 cycle adds one cycle.
- Throughput: one word per en=1 cycle; no back-pressure output.
- Reset values (one edge after rst=1): q=RST_VAL, q_valid=0, count=0.
- Reset or flush mid-stream takes effect on the same edge; in-flight words are lost and never appear on q_valid.
- Outputs are undefined before the first reset edge.

## Configuration
- Macro REG_PIPE_COUNT_EN.
  - Defined: count port and occupancy register present, behaving as above.
  - Undefined: count port and register removed; all other behaviour is identical.
- The bench checks count only under this macro.

## Test plan
Benches use WIDTH=8, DEPTH=3, RST_VAL=8'h00, with REG_PIPE_COUNT_EN defined.
- Reset:
  - stimulus: rst=1 with d=8'hab, d_valid=1, en=1 for 2 edges
  - required: q=8'h00, q_valid=0, count=0
- Streaming latency:
  - stimulus: rst=0, en=1, send 8'h11, 8'h22, 8'h33 on consecutive edges, then d_valid=0
  - required: q_valid rises 3 cycles after 8'h11 enters; q reads 11, 22, 33 on consecutive cycles; count reaches 3, then falls to 0; q holds 8'h33 after q_valid falls
- Stall:
  - stimulus: 8'h5a enters, then en=0 for 4 cycles
  - required: q_valid stays 0, count stays 1; q=8'h5a appears 2 en=1 edges after en returns
- Bubble gating:
  - stimulus: valid 8'hc3, invalid d=8'hff, valid 8'h3c
  - required: q shows c3; then q_valid=0 with q still c3; then 3c; 8'hff never appears on q
- Flush with en:
  - stimulus: 3 valid words in flight, then flush=1, en=1, d=8'h77, d_valid=1
  - required: next edge q_valid=0 and count=0; 8'h77 and the in-flight words never appear with q_valid=1
- Reset over flush and count:
  - stimulus: rst=1 and flush=1 with the chain full
  - required: q=8'h00, q_valid=0
  - stimulus: count check with d_valid=1 while q_valid=1
  - required: count unchanged

Source files
------------

// File: rtl/reg_pipe_en_rst.sv
// rtl/reg_pipe_en_rst.sv - stallable, flushable pipeline register chain with per-stage valid
//
// Purpose:
//   A chain of DEPTH registers, each WIDTH bits wide, with a valid bit per stage.
//   A common enable stalls the whole chain. Flush invalidates every stage and the incoming word.
//   Data registers load only when the word moving into them is valid, so bubbles never toggle data.
//   The optional occupancy counter is built only when the macro REG_PIPE_COUNT_EN is defined.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   en       in   advance enable (0 = whole chain holds)
//   flush    in   invalidate all stages and discard d/d_valid
//   d        in   WIDTH-bit input data
//   d_valid  in   d carries a valid word
//   q        out  last-stage data (registered)
//   q_valid  out  last-stage valid (registered)
//   count    out  number of valid stages (REG_PIPE_COUNT_EN only)
module reg_pipe_en_rst #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [CW-1:0]    count
`endif
);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;

  always_comb begin
    s_d = s_q;
    v_d = v_q;
    if (flush) begin
      // Data is left in place; only the valid bits are cleared.
      v_d = '0;
    end else if (en) begin
      v_d[0] = d_valid;
      if (d_valid) s_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1];
        // Bubbles do not move into a data register; it keeps its last word.
        if (v_q[i-1]) s_d[i] = s_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= RST_VAL;
      v_q <= '0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  assign q       = s_q[DEPTH-1];
  assign q_valid = v_q[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (en) begin
      // Entry and exit on the same edge cancel; range stays within 0..DEPTH.
      count_d = count_q + CW'(d_valid) - CW'(v_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_reg_pipe_en_rst.sv
// tb/tb_reg_pipe_en_rst.sv - directed self-checking bench for reg_pipe_en_rst
module tb_reg_pipe_en_rst;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;
  logic [7:0] q;
  logic       q_valid;
`ifdef REG_PIPE_COUNT_EN
  logic [1:0] count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reg_pipe_en_rst #(
    .WIDTH  (8),
    .DEPTH  (3),
    .RST_VAL(8'h00)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .flush  (flush),
    .d      (d),
    .d_valid(d_valid),
    .q      (q),
    .q_valid(q_valid)
`ifdef REG_PIPE_COUNT_EN
    ,
    .count  (count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef REG_PIPE_COUNT_EN
    check(tag, 32'(count), exp);
`endif
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_q, input logic exp_v);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_qv"}, 32'(q_valid), 32'(exp_v));
  endtask

  // One rising edge, then sample 1 time unit later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] dd, input logic vv);
    d = dd;
    d_valid = vv;
    step();
  endtask

  initial begin
    #1;
    // Reset dominates live input
    rst = 1'b1; en = 1'b1; d = 8'hab; d_valid = 1'b1;
    step();
    step();
    check_out("reset", 8'h00, 1'b0);
    check_cnt("reset_cnt", 0);
    rst = 1'b0;

    // Streaming latency
    drive(8'h11, 1'b1);
    check("lat_e1_qv", 32'(q_valid), 0);
    drive(8'h22, 1'b1);
    check("lat_e2_qv", 32'(q_valid), 0);
    drive(8'h33, 1'b1);
    check_out("stream_11", 8'h11, 1'b1);
    check_cnt("stream_cnt3", 3);
    drive(8'h00, 1'b0);
    check_out("stream_22", 8'h22, 1'b1);
    check_cnt("stream_cnt2", 2);
    step();
    check_out("stream_33", 8'h33, 1'b1);
    check_cnt("stream_cnt1", 1);
    step();
    check_out("stream_hold33", 8'h33, 1'b0);
    check_cnt("stream_cnt0", 0);

    // Stall
    drive(8'h5a, 1'b1);
    check_cnt("stall_cnt_in", 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'hee, 1'b1);
      check("stall_qv", 32'(q_valid), 0);
      check_cnt("stall_cnt", 1);
    end
    en = 1'b1;
    drive(8'h00, 1'b0);
    check("stall_resume1_qv", 32'(q_valid), 0);
    step();
    check_out("stall_out", 8'h5a, 1'b1);
    step();
    check_out("stall_drain", 8'h5a, 1'b0);
    check_cnt("stall_cnt0", 0);

    // Bubble gating
    drive(8'hc3, 1'b1);
    drive(8'hff, 1'b0);
    drive(8'h3c, 1'b1);
    check_out("bubble_c3", 8'hc3, 1'b1);
    drive(8'h00, 1'b0);
    check_out("bubble_gap", 8'hc3, 1'b0);
    step();
    check_out("bubble_3c", 8'h3c, 1'b1);
    step();
    check_out("bubble_hold", 8'h3c, 1'b0);
    check_cnt("bubble_cnt0", 0);

    // Flush with en
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b1);
    drive(8'h03, 1'b1);
    check_out("preflush", 8'h01, 1'b1);
    check_cnt("preflush_cnt", 3);
    flush = 1'b1;
    drive(8'h77, 1'b1);
    flush = 1'b0;
    check_out("flush", 8'h01, 1'b0);
    check_cnt("flush_cnt", 0);
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("postflush_qv", 32'(q_valid), 0);
    end
    check_cnt("postflush_cnt", 0);

    // Reset wins over flush with the chain full
    drive(8'ha1, 1'b1);
    drive(8'ha2, 1'b1);
    drive(8'ha3, 1'b1);
    check_out("prerst", 8'ha1, 1'b1);
    rst = 1'b1; flush = 1'b1;
    drive(8'ha4, 1'b1);
    rst = 1'b0; flush = 1'b0;
    check_out("rst_flush", 8'h00, 1'b0);
    check_cnt("rst_flush_cnt", 0);

    // Simultaneous entry and exit keep count
    drive(8'hb1, 1'b1);
    drive(8'hb2, 1'b1);
    drive(8'hb3, 1'b1);
    check_out("full_b1", 8'hb1, 1'b1);
    check_cnt("full_cnt", 3);
    drive(8'hb4, 1'b1);
    check_out("inout_b2", 8'hb2, 1'b1);
    check_cnt("inout_cnt", 3);
    en = 1'b0;
    drive(8'hcc, 1'b1);
    check_out("hold_b2", 8'hb2, 1'b1);
    check_cnt("hold_cnt", 3);
    en = 1'b1;
    drive(8'h00, 1'b0);
    check_out("drain_b3", 8'hb3, 1'b1);
    check_cnt("drain_cnt", 2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
